// File: rtl/cr16_datapath_reader.sv
// Steps r0..r(LAST_REG) through the ALU as a non-writing pass-through, latches each value for display
// and compares it with a running Fibonacci reference; 2+DWELL_CYCLES cycles per register, no backpressure.
module cr16_datapath_reader #(
  parameter int unsigned LAST_REG     = 7,
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic        I_START,
  input  logic [15:0] I_RESULT_BUS,
  output logic [15:0] O_REG_WRITE_ENABLE,
  output logic [3:0]  O_REG_A_SELECT,
  output logic [3:0]  O_REG_B_SELECT,
  output logic        O_IMMEDIATE_SELECT,
  output logic [15:0] O_IMMEDIATE,
  output logic [3:0]  O_OPCODE,
  output logic [15:0] O_VALUE,
  output logic [3:0]  O_INDEX,
  output logic        O_VALID,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic        O_MISMATCH
);

  localparam logic [3:0]  LAST_IDX   = 4'(LAST_REG);
  localparam bit          NO_DWELL   = (DWELL_CYCLES == 0);
  localparam logic [31:0] DWELL_LAST = NO_DWELL ? 32'd0 : 32'(DWELL_CYCLES - 1);
  localparam logic [3:0]  OP_ADDU    = 4'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CAPTURE,
    S_DWELL,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  index;
  logic [15:0] exp_a;
  logic [15:0] exp_b;
  logic [31:0] dwell_cnt;

  logic start_acc;
  logic dwell_end;
  logic step_exit;
  logic last_reg;

  assign start_acc = ((state == S_IDLE) || (state == S_DONE)) && I_START;
  assign dwell_end = (state == S_DWELL) && (dwell_cnt == DWELL_LAST);
  // With no hold time the capture cycle itself closes out the register.
  assign step_exit = dwell_end || ((state == S_CAPTURE) && NO_DWELL);
  assign last_reg  = (index == LAST_IDX);

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (I_START) state_nxt = S_SELECT;
      S_SELECT:  state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (!NO_DWELL)     state_nxt = S_DWELL;
        else if (last_reg) state_nxt = S_DONE;
        else               state_nxt = S_SELECT;
      end
      S_DWELL: begin
        if (dwell_end) state_nxt = last_reg ? S_DONE : S_SELECT;
      end
      S_DONE:    if (I_START) state_nxt = S_SELECT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    O_BUSY             = (state == S_SELECT) || (state == S_CAPTURE) || (state == S_DWELL);
    O_DONE             = (state == S_DONE);
    O_REG_WRITE_ENABLE = 16'h0000;
    O_REG_A_SELECT     = index;
    O_REG_B_SELECT     = 4'h0;
    O_IMMEDIATE        = 16'h0000;
    O_IMMEDIATE_SELECT = O_BUSY;
    O_OPCODE           = O_BUSY ? OP_ADDU : 4'h0;
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      index      <= 4'h0;
      exp_a      <= 16'h0000;
      exp_b      <= 16'h0000;
      dwell_cnt  <= 32'd0;
      O_VALUE    <= 16'h0000;
      O_INDEX    <= 4'h0;
      O_VALID    <= 1'b0;
      O_MISMATCH <= 1'b0;
    end else begin
      O_VALID <= 1'b0;
      if (start_acc) begin
        index      <= 4'h0;
        exp_a      <= 16'h0001;
        exp_b      <= 16'h0001;
        O_MISMATCH <= 1'b0;
      end
      if (state == S_CAPTURE) begin
        O_VALUE   <= I_RESULT_BUS;
        O_INDEX   <= index;
        O_VALID   <= 1'b1;
        exp_a     <= exp_b;
        exp_b     <= exp_a + exp_b;
        dwell_cnt <= 32'd0;
        if (I_RESULT_BUS != exp_a) O_MISMATCH <= 1'b1;
      end
      if (state == S_DWELL) begin
        dwell_cnt <= dwell_cnt + 32'd1;
      end
      // The final register never increments, so index cannot wrap past 15.
      if (step_exit && !last_reg) begin
        index <= index + 4'h1;
      end
    end
  end

endmodule

// File: tb/tb_cr16_datapath_reader.sv
// Three reader instances (LAST/DWELL = 7/2, 7/0, 15/1) each driving a modelled register file;
// a scoreboard holds per-capture expectations, a forked monitor pops them on every O_VALID.
module tb_cr16_datapath_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic        nrst   [3] = '{1'b0, 1'b0, 1'b0};
  logic        start  [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] bus    [3];
  logic [15:0] wen    [3];
  logic [3:0]  asel   [3];
  logic [3:0]  bsel   [3];
  logic        immsel [3];
  logic [15:0] imm    [3];
  logic [3:0]  opc    [3];
  logic [15:0] val    [3];
  logic [3:0]  idx    [3];
  logic        vld    [3];
  logic        busy   [3];
  logic        done   [3];
  logic        mis    [3];

  logic [15:0] regs [3][16];
  logic [15:0] fibv [16];

  typedef struct {
    int          k;
    int          i;
    logic [15:0] v;
    logic        m;
    int unsigned c;
  } exp_t;
  exp_t sbq[$];

  function automatic int lr_of(int k);
    return (k == 2) ? 15 : 7;
  endfunction

  function automatic int dw_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 1);
  endfunction

  generate
    for (genvar g = 0; g < 3; g++) begin : gi
      cr16_datapath_reader #(
        .LAST_REG    ((g == 2) ? 15 : 7),
        .DWELL_CYCLES((g == 0) ? 2 : ((g == 1) ? 0 : 1))
      ) u_dut (
        .I_CLK             (clk),
        .I_NRESET          (nrst[g]),
        .I_START           (start[g]),
        .I_RESULT_BUS      (bus[g]),
        .O_REG_WRITE_ENABLE(wen[g]),
        .O_REG_A_SELECT    (asel[g]),
        .O_REG_B_SELECT    (bsel[g]),
        .O_IMMEDIATE_SELECT(immsel[g]),
        .O_IMMEDIATE       (imm[g]),
        .O_OPCODE          (opc[g]),
        .O_VALUE           (val[g]),
        .O_INDEX           (idx[g]),
        .O_VALID           (vld[g]),
        .O_BUSY            (busy[g]),
        .O_DONE            (done[g]),
        .O_MISMATCH        (mis[g])
      );
      // Datapath stand-in: opcode 1 adds operand B (register or immediate) to register A.
      assign bus[g] = (opc[g] == 4'd1) ?
                      (regs[g][asel[g]] + (immsel[g] ? imm[g] : regs[g][bsel[g]])) : 16'h0000;
    end
  endgenerate

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_scan(input int k, input int unsigned t, input int n);
    exp_t e;
    logic m;
    m = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (regs[k][i] != fibv[i]) m = 1'b1;
      e.k = k;
      e.i = i;
      e.v = regs[k][i];
      e.m = m;
      e.c = t + 2 + i * (2 + dw_of(k));
      sbq.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (nrst[k]) begin
          chk("ctrl_lines", {wen[k], bsel[k], imm[k], immsel[k], opc[k]},
              {16'h0, 4'h0, 16'h0, busy[k], (busy[k] ? 4'd1 : 4'd0)});
        end
        if (vld[k]) begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid: inst %0d index %0d value 0x%0h, expected no capture",
                     k, idx[k], val[k]);
          end else begin
            e = sbq.pop_front();
            chk("vld_inst", 64'(k), 64'(e.k));
            chk("vld_index", 64'(idx[k]), 64'(e.i));
            chk("vld_value", 64'(val[k]), 64'(e.v));
            chk("vld_mismatch", 64'(mis[k]), 64'(e.m));
            chk("vld_cycle", 64'(cyc), 64'(e.c));
          end
        end
      end
    end
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_status"}, {val[k], idx[k], vld[k], busy[k], done[k], mis[k]}, 64'h0);
    chk({tag, "_ctrl"}, {asel[k], bsel[k], wen[k], immsel[k], imm[k], opc[k]}, 64'h0);
  endtask

  // Called just after a negedge; returns the edge that samples I_START.
  task automatic start_scan(input int k, input int n, input bit hold, output int unsigned t);
    start[k] = 1'b1;
    t = cyc + 1;
    push_scan(k, t, n);
    @(negedge clk);
    if (!hold) start[k] = 1'b0;
    chk("start_busy", 64'(busy[k]), 64'h1);
    chk("start_asel", 64'(asel[k]), 64'h0);
    chk("start_mis_clear", 64'(mis[k]), 64'h0);
  endtask

  task automatic wait_done(input int k, input int unsigned t);
    int   b;
    logic m;
    b = 0;
    while (!done[k] && b < 2000) begin
      @(negedge clk);
      b++;
    end
    m = 1'b0;
    for (int i = 0; i <= lr_of(k); i++) if (regs[k][i] != fibv[i]) m = 1'b1;
    chk("done_seen", 64'(done[k]), 64'h1);
    chk("done_cycle", 64'(cyc), 64'(t + (lr_of(k) + 1) * (2 + dw_of(k))));
    chk("done_hold", {val[k], idx[k], mis[k]}, {regs[k][lr_of(k)], 4'(lr_of(k)), m});
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 5)) @(negedge clk);
  endtask

  task automatic load_fib(input int k);
    for (int i = 0; i < 16; i++) regs[k][i] = fibv[i];
  endtask

  task automatic load_random(input int k);
    for (int i = 0; i < 16; i++)
      regs[k][i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : fibv[i];
  endtask

  initial begin
    int unsigned t;
    int unsigned t2;

    fibv[0] = 16'd1;
    fibv[1] = 16'd1;
    for (int i = 2; i < 16; i++) fibv[i] = 16'((32'(fibv[i-1]) + 32'(fibv[i-2])) % 65536);
    for (int k = 0; k < 3; k++) load_fib(k);

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_zero(k, "reset");
    for (int k = 0; k < 3; k++) nrst[k] = 1'b1;
    @(negedge clk);

    // Clean scan, then DONE must hold its results while I_START stays low.
    gap();
    start_scan(0, 8, 1'b0, t);
    wait_done(0, t);
    repeat (4) @(negedge clk);
    chk("done_persist", {done[0], busy[0], val[0], idx[0]}, {1'b1, 1'b0, 16'd21, 4'd7});

    // r5 corrupted: sticky mismatch from index 5 through DONE.
    regs[0][5] = 16'd9;
    gap();
    start_scan(0, 8, 1'b0, t);
    wait_done(0, t);

    // Held start: restart clears mismatch, DONE lasts one cycle, busy ignores start.
    regs[0][5] = 16'd8;
    gap();
    start_scan(0, 8, 1'b1, t);
    t2 = t + (lr_of(0) + 1) * (2 + dw_of(0)) + 1;
    push_scan(0, t2, 8);
    wait_done(0, t);
    @(negedge clk);
    chk("done_one_cycle", {done[0], busy[0], mis[0], asel[0]}, {1'b0, 1'b1, 1'b0, 4'd0});
    start[0] = 1'b0;
    wait_done(0, t2);

    // Reset during the second DWELL cycle of index 3.
    gap();
    start_scan(0, 4, 1'b0, t);
    while (cyc < t + 15) @(negedge clk);
    chk("pre_reset_dwell", {busy[0], idx[0], asel[0]}, {1'b1, 4'd3, 4'd3});
    #2 nrst[0] = 1'b0;
    #1 chk_zero(0, "async_reset");
    @(negedge clk);
    chk_zero(0, "held_reset");
    nrst[0] = 1'b1;
    chk("sb_drained_reset", 64'(sbq.size()), 64'h0);
    @(negedge clk);
    start_scan(0, 8, 1'b0, t);
    wait_done(0, t);

    // No dwell: captures every 2 cycles, random corruption patterns.
    for (int r = 0; r < 3; r++) begin
      if (r == 0) load_fib(1);
      else load_random(1);
      gap();
      start_scan(1, 8, 1'b0, t);
      wait_done(1, t);
    end

    // Full 16-register scan.
    for (int r = 0; r < 2; r++) begin
      if (r == 0) load_fib(2);
      else load_random(2);
      gap();
      start_scan(2, 16, 1'b0, t);
      wait_done(2, t);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty_end", 64'(sbq.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
